keypad_entry: RTL and testbench

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_pkg.sv | 34 +++
 rtl/keypad_if.sv | 28 ++
 rtl/keypad_scanner.sv | 93 +++++++++
 rtl/keypad_entry.sv | 153 +++++++++++++++
 tb/tb_keypad_entry.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the oven keypad entry block.
//   - parameter defaults for the scan divider and debounce depth
//   - key codes for the two command keys (clear, start)
//   - entry FSM state encoding
//   - key_map(): (row, column) -> key code lookup for the 4x3 keypad
package keypad_pkg;

    localparam int SCAN_DIV_DEFAULT = 1000;
    localparam int DEBOUNCE_DEFAULT = 4;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_START = 4'hB;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Rows 0..2 hold digits 1..9 in reading order; row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        if (row == 2'd3) begin
            case (col)
                2'd0:    key_map = KEY_CLEAR;
                2'd1:    key_map = 4'd0;
                default: key_map = KEY_START;
            endcase
        end else begin
            key_map = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: bundles the keypad matrix pins, the oven-idle qualifier and the
// entry outputs (BCD time, key event, command pulses).
//   master : the keypad_entry block (drives rows and all results)
//   slave  : the surrounding system (drives enable and the column pins)
interface keypad_if;
    logic       enable;
    logic [2:0] col_in;
    logic [3:0] row_out;
    logic [3:0] seconds_ones;
    logic [3:0] seconds_tens;
    logic [3:0] minutes;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start_pulse;
    logic       clear_pulse;

    modport master (
        input  enable, col_in,
        output row_out, seconds_ones, seconds_tens, minutes,
               key_valid, key_code, start_pulse, clear_pulse
    );

    modport slave (
        output enable, col_in,
        input  row_out, seconds_ones, seconds_tens, minutes,
               key_valid, key_code, start_pulse, clear_pulse
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives the keypad rows one at a time and decodes one full
// four-row scan into a single key observation.
//   clk, rst     : system clock, async active-high reset
//   col_in       : raw active-low columns (asynchronous to clk)
//   row_out      : active-low row drive, exactly one bit low
//   scan_done    : one-cycle pulse after the last row of a scan is sampled
//   key_present  : with scan_done, exactly one key was down in the scan
//   key_code     : with scan_done and key_present, the code of that key
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] col_in,
    output logic [3:0] row_out,
    output logic       scan_done,
    output logic       key_present,
    output logic [3:0] key_code
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [2:0]    col_meta, col_sync;
    logic [DW-1:0] div_cnt;
    logic [1:0]    row;
    logic          acc_found, acc_bad;
    logic [3:0]    acc_code;

    logic          slot_end;
    logic [2:0]    col_low;
    logic          row_hit, row_multi, prev_found, prev_bad;
    logic [1:0]    hit_col;
    logic          found_n, bad_n;
    logic [3:0]    code_n;

    assign slot_end = (div_cnt == DW'(SCAN_DIV - 1));
    assign row_out  = ~(4'b0001 << row);

    // Fold the current row's sample into the running scan result. Row 0
    // starts a fresh scan, so the accumulators are ignored there.
    always_comb begin
        // NOTE: every signal gets a value before any branch so no latch is inferred.
        col_low    = ~col_sync;
        row_hit    = |col_low;
        row_multi  = (col_low[0] & col_low[1]) | (col_low[0] & col_low[2]) |
                     (col_low[1] & col_low[2]);
        hit_col    = col_low[0] ? 2'd0 : (col_low[1] ? 2'd1 : 2'd2);
        prev_found = (row == 2'd0) ? 1'b0 : acc_found;
        prev_bad   = (row == 2'd0) ? 1'b0 : acc_bad;
        found_n    = prev_found | row_hit;
        // Two columns in one row, or hits in two rows, make the scan ambiguous.
        bad_n      = prev_bad | row_multi | (prev_found & row_hit);
        code_n     = row_hit ? key_map(row, hit_col) : acc_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Idle columns read high, so the synchronizer resets to released.
            col_meta    <= 3'b111;
            col_sync    <= 3'b111;
            div_cnt     <= '0;
            row         <= 2'd0;
            acc_found   <= 1'b0;
            acc_bad     <= 1'b0;
            acc_code    <= 4'd0;
            scan_done   <= 1'b0;
            key_present <= 1'b0;
            key_code    <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            col_meta  <= col_in;
            col_sync  <= col_meta;
            scan_done <= 1'b0;
            if (slot_end) begin
                div_cnt   <= '0;
                row       <= row + 2'd1;
                acc_found <= found_n;
                acc_bad   <= bad_n;
                acc_code  <= code_n;
                if (row == 2'd3) begin
                    scan_done   <= 1'b1;
                    key_present <= found_n & ~bad_n;
                    key_code    <= code_n;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: oven cook-time keypad. Scans a 4x3 matrix, debounces presses
// and releases over whole scans, and shifts digits into an M:SS BCD display.
//   clk, rst : system clock, async active-high reset
//   kif      : keypad_if.master -- enable, col_in in; row_out, minutes,
//              seconds_tens, seconds_ones, key_valid, key_code,
//              start_pulse, clear_pulse out
// '*' clears the time, '#' requests start, digits shift in from the right.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT,
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input logic      clk,
    input logic      rst,
    keypad_if.master kif
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    cand, cand_n;
    logic          accept;

    logic          scan_done, key_present;
    logic [3:0]    scan_code;

    logic [1:0]    entry_cnt;
    logic [3:0]    ones, tens, mins;
    logic          key_valid_q, start_q, clear_q;
    logic [3:0]    key_code_q;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk        (clk),
        .rst        (rst),
        .col_in     (kif.col_in),
        .row_out    (kif.row_out),
        .scan_done  (scan_done),
        .key_present(key_present),
        .key_code   (scan_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SCAN;
            cnt   <= '0;
            cand  <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
        end
    end

    // Debounce FSM: advances only on scan boundaries. accept marks the one
    // scan on which a press becomes confirmed.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        accept  = 1'b0;
        if (scan_done) begin
            unique case (state)
                SCAN: if (key_present) begin
                    cand_n = scan_code;
                    cnt_n  = CW'(1);
                    if (DEBOUNCE <= 1) begin
                        state_n = HELD;
                        accept  = 1'b1;
                    end else begin
                        state_n = CONFIRM;
                    end
                end
                CONFIRM: if (key_present && scan_code == cand) begin
                    if (int'(cnt) + 1 >= DEBOUNCE) begin
                        state_n = HELD;
                        accept  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    state_n = SCAN;
                end
                HELD: if (!key_present) begin
                    cnt_n   = CW'(1);
                    state_n = (DEBOUNCE <= 1) ? SCAN : RELEASE;
                end
                RELEASE: if (key_present) begin
                    state_n = HELD;
                end else if (int'(cnt) + 1 >= DEBOUNCE) begin
                    state_n = SCAN;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
                default: state_n = SCAN;
            endcase
        end
    end

    // Time entry. An entry count of zero means the next digit starts a new
    // time from 0:00, which is how a digit after '#' replaces the old time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_cnt   <= 2'd0;
            ones        <= 4'd0;
            tens        <= 4'd0;
            mins        <= 4'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            key_valid_q <= accept;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
            if (accept) begin
                key_code_q <= scan_code;
                if (scan_code == KEY_CLEAR) begin
                    ones      <= 4'd0;
                    tens      <= 4'd0;
                    mins      <= 4'd0;
                    entry_cnt <= 2'd0;
                    clear_q   <= 1'b1;
                end else if (scan_code == KEY_START) begin
                    start_q   <= kif.enable & (|{mins, tens, ones});
                    entry_cnt <= 2'd0;
                end else if (kif.enable && entry_cnt == 2'd0) begin
                    mins      <= 4'd0;
                    tens      <= 4'd0;
                    ones      <= scan_code;
                    entry_cnt <= 2'd1;
                end else if (kif.enable && entry_cnt != 2'd3 && ones <= 4'd5) begin
                    // Shifting is refused when the old ones digit would
                    // become a tens-of-seconds digit above 5.
                    mins      <= tens;
                    tens      <= ones;
                    ones      <= scan_code;
                    entry_cnt <= entry_cnt + 2'd1;
                end
            end
        end
    end

    assign kif.seconds_ones = ones;
    assign kif.seconds_tens = tens;
    assign kif.minutes      = mins;
    assign kif.key_valid    = key_valid_q;
    assign kif.key_code     = key_code_q;
    assign kif.start_pulse  = start_q;
    assign kif.clear_pulse  = clear_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed, table-driven bench for keypad_entry with
// SCAN_DIV=4, DEBOUNCE=2. A behavioural keypad model pulls columns low for
// the pressed keys on the currently driven row.
module tb_keypad_entry;
    import keypad_pkg::*;

    localparam int SCAN_DIV  = 4;
    localparam int DEBOUNCE  = 2;
    localparam int SCAN_CLKS = 4 * SCAN_DIV;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_if kif ();

    keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk),
        .rst(rst),
        .kif(kif)
    );

    // Keypad model: bit r*3+c set means key at (row r, column c) is down.
    logic [11:0] pressed = 12'h000;
    logic [2:0]  col_model;
    always_comb begin
        col_model = 3'b111;
        for (int r = 0; r < 4; r++)
            if (!kif.row_out[r])
                for (int c = 0; c < 3; c++)
                    if (pressed[r*3 + c]) col_model[c] = 1'b0;
    end
    assign kif.col_in = col_model;

    function automatic logic [11:0] kmask(input logic [3:0] k);
        logic [11:0] one;
        one = 12'h001;
        case (k)
            4'd0:    kmask = one << 10;
            4'hA:    kmask = one << 9;
            4'hB:    kmask = one << 11;
            default: kmask = one << (k - 4'd1);
        endcase
    endfunction

    // Pulse monitor, sampled on the falling edge.
    int kv_total = 0, st_total = 0, cl_total = 0, stray = 0;
    always @(negedge clk) begin
        if (kif.key_valid)   kv_total <= kv_total + 1;
        if (kif.start_pulse) st_total <= st_total + 1;
        if (kif.clear_pulse) cl_total <= cl_total + 1;
        if ((kif.start_pulse || kif.clear_pulse) && !kif.key_valid) stray <= stray + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Return on the falling edge just after row_out re-enters 1110.
    task automatic align(input string name);
        logic [3:0] prev;
        bit         found;
        found = 1'b0;
        prev  = kif.row_out;
        for (int n = 0; n < 4 * SCAN_CLKS && !found; n++) begin
            @(negedge clk);
            if (prev != 4'b1110 && kif.row_out == 4'b1110) found = 1'b1;
            prev = kif.row_out;
        end
        check({name, "_align"}, 32'(found), 32'd1);
    endtask

    typedef struct {
        logic [11:0] mask;
        int          scans;
        logic        en;
        int          kv;
        logic [3:0]  code;
        logic [11:0] tm;     // {minutes, seconds_tens, seconds_ones}
        int          st;
        int          cl;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] cur_time();
        return {kif.minutes, kif.seconds_tens, kif.seconds_ones};
    endfunction

    initial begin
        logic [3:0] rot_exp[4];
        int kv0, st0, cl0;
        string nm;

        rot_exp[0] = 4'b1101; rot_exp[1] = 4'b1011;
        rot_exp[2] = 4'b0111; rot_exp[3] = 4'b1110;

        // Single '5' held 5 scans; '*' clear
        vecs.push_back('{kmask(4'd5), 5, 1'b1, 1, 4'h5, 12'h005, 0, 0});
        vecs.push_back('{kmask(4'hA), 3, 1'b1, 1, 4'hA, 12'h000, 0, 1});
        // 1,3,0,7 -> 1:30, fourth ignored
        vecs.push_back('{kmask(4'd1), 3, 1'b1, 1, 4'h1, 12'h001, 0, 0});
        vecs.push_back('{kmask(4'd3), 3, 1'b1, 1, 4'h3, 12'h013, 0, 0});
        vecs.push_back('{kmask(4'd0), 3, 1'b1, 1, 4'h0, 12'h130, 0, 0});
        vecs.push_back('{kmask(4'd7), 3, 1'b1, 1, 4'h7, 12'h130, 0, 0});
        // One-scan glitch of '8'
        vecs.push_back('{kmask(4'd8), 1, 1'b1, 0, 4'h7, 12'h130, 0, 0});
        vecs.push_back('{kmask(4'hA), 3, 1'b1, 1, 4'hA, 12'h000, 0, 1});
        // 9 then 2: tens above 5 refused
        vecs.push_back('{kmask(4'd9), 3, 1'b1, 1, 4'h9, 12'h009, 0, 0});
        vecs.push_back('{kmask(4'd2), 3, 1'b1, 1, 4'h2, 12'h009, 0, 0});
        vecs.push_back('{kmask(4'hA), 3, 1'b1, 1, 4'hA, 12'h000, 0, 1});
        // 1,0,0 then '#' variants
        vecs.push_back('{kmask(4'd1), 3, 1'b1, 1, 4'h1, 12'h001, 0, 0});
        vecs.push_back('{kmask(4'd0), 3, 1'b1, 1, 4'h0, 12'h010, 0, 0});
        vecs.push_back('{kmask(4'd0), 3, 1'b1, 1, 4'h0, 12'h100, 0, 0});
        vecs.push_back('{kmask(4'hB), 3, 1'b1, 1, 4'hB, 12'h100, 1, 0});
        vecs.push_back('{kmask(4'hB), 3, 1'b0, 1, 4'hB, 12'h100, 0, 0});
        vecs.push_back('{kmask(4'hA), 3, 1'b1, 1, 4'hA, 12'h000, 0, 1});
        vecs.push_back('{kmask(4'hB), 3, 1'b1, 1, 4'hB, 12'h000, 0, 0});
        // Digit after '#' restarts from 0:00
        vecs.push_back('{kmask(4'd4), 3, 1'b1, 1, 4'h4, 12'h004, 0, 0});
        vecs.push_back('{kmask(4'hB), 3, 1'b1, 1, 4'hB, 12'h004, 1, 0});
        vecs.push_back('{kmask(4'd6), 3, 1'b1, 1, 4'h6, 12'h006, 0, 0});
        // Digit with enable low: event only
        vecs.push_back('{kmask(4'd2), 3, 1'b0, 1, 4'h2, 12'h006, 0, 0});
        // Ambiguous scans: two keys in one row, keys in two rows
        vecs.push_back('{kmask(4'd1) | kmask(4'd2), 3, 1'b1, 0, 4'h2, 12'h006, 0, 0});
        vecs.push_back('{kmask(4'd1) | kmask(4'd4), 3, 1'b1, 0, 4'h2, 12'h006, 0, 0});
        // '*' clears regardless of enable
        vecs.push_back('{kmask(4'hA), 3, 1'b0, 1, 4'hA, 12'h000, 0, 1});
        vecs.push_back('{kmask(4'd7), 3, 1'b1, 1, 4'h7, 12'h007, 0, 0});

        // Reset state
        kif.enable = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_row_out",   32'(kif.row_out),   32'hE);
        check("rst_time",      32'(cur_time()),    32'h000);
        check("rst_key_code",  32'(kif.key_code),  32'h0);
        check("rst_pulses",    32'({kif.key_valid, kif.start_pulse, kif.clear_pulse}), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Row rotation, one step every SCAN_DIV clocks
        for (int s = 0; s < 4; s++) begin
            repeat (SCAN_DIV) @(posedge clk);
            #1;
            check($sformatf("row_step%0d", s), 32'(kif.row_out), 32'(rot_exp[s]));
        end

        foreach (vecs[i]) begin
            nm = $sformatf("v%0d", i);
            align(nm);
            kif.enable = vecs[i].en;
            kv0 = kv_total; st0 = st_total; cl0 = cl_total;
            pressed = vecs[i].mask;
            repeat (vecs[i].scans * SCAN_CLKS) @(negedge clk);
            pressed = 12'h000;
            repeat (4 * SCAN_CLKS) @(negedge clk);
            check({nm, "_key_valid_count"}, 32'(kv_total - kv0), 32'(vecs[i].kv));
            check({nm, "_key_code"},        32'(kif.key_code),   32'(vecs[i].code));
            check({nm, "_time"},            32'(cur_time()),     32'(vecs[i].tm));
            check({nm, "_start_count"},     32'(st_total - st0), 32'(vecs[i].st));
            check({nm, "_clear_count"},     32'(cl_total - cl0), 32'(vecs[i].cl));
        end

        // Reset while '4' is in CONFIRM; key stays held through reset
        align("rst4");
        kif.enable = 1'b1;
        pressed = kmask(4'd4);
        kv0 = kv_total;
        repeat (SCAN_CLKS + 4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_row_out",  32'(kif.row_out),  32'hE);
        check("mid_rst_time",     32'(cur_time()),   32'h000);
        check("mid_rst_key_code", 32'(kif.key_code), 32'h0);
        check("mid_rst_pulses",   32'({kif.key_valid, kif.start_pulse, kif.clear_pulse}), 32'h0);
        check("pre_rst_no_kv",    32'(kv_total - kv0), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        kv0 = kv_total;
        repeat (20) @(negedge clk);
        check("post_rst_kv_after_1_scan", 32'(kv_total - kv0), 32'd0);
        repeat (20) @(negedge clk);
        check("post_rst_kv_after_2_scans", 32'(kv_total - kv0), 32'd1);
        check("post_rst_key_code", 32'(kif.key_code), 32'h4);
        check("post_rst_time",     32'(cur_time()),   32'h004);
        pressed = 12'h000;
        repeat (4 * SCAN_CLKS) @(negedge clk);

        check("pulse_outside_key_valid", 32'(stray), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
